// File: rtl/change_dispenser_ctrl.sv
// Change payout sequencer: pays an amount greedily from five coin hoppers,
// one solenoid pulse per coin, skipping empty hoppers, with abort support.
module change_dispenser_ctrl #(
  parameter int AMT_W        = 10,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             abort,
  input  logic [4:0]       hopper_empty,
  output logic [4:0]       eject,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    PULSE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int MAX_CNT = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  function automatic logic [AMT_W-1:0] denom(input logic [2:0] idx);
    case (idx)
      3'd4:    return AMT_W'(100);
      3'd3:    return AMT_W'(50);
      3'd2:    return AMT_W'(25);
      3'd1:    return AMT_W'(10);
      default: return AMT_W'(5);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       coin_q, coin_d;
  logic [4:0]       eject_q, eject_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;

  logic [4:0] fit;
  logic       found;
  logic [2:0] pick_idx;

  // A hopper is a candidate when it has coins and its value still fits.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_fit
      assign fit[gi] = !hopper_empty[gi] && (denom(3'(gi)) <= remaining_q);
    end
  endgenerate

  // Ascending scan so the highest fitting denomination wins.
  always_comb begin
    found    = 1'b0;
    pick_idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (fit[i]) begin
        found    = 1'b1;
        pick_idx = 3'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coin_d      = coin_q;
    eject_d     = eject_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    remaining_d = remaining_q;

    case (state_q)
      IDLE: begin
        eject_d = 5'b00000;
        if (start) begin
          remaining_d = amount;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          state_d     = SELECT;
        end
      end

      SELECT: begin
        if (abort) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (found) begin
          coin_d  = pick_idx;
          eject_d = 5'b00001 << pick_idx;
          cnt_d   = '0;
          state_d = PULSE;
        end else begin
          err_d   = (remaining_q != '0);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      PULSE: begin
        if (abort) begin
          // Interrupted coin is not counted as paid.
          eject_d = 5'b00000;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == PULSE_LAST) begin
          eject_d     = 5'b00000;
          remaining_d = remaining_q - denom(coin_q);
          cnt_d       = '0;
          state_d     = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        eject_d = 5'b00000;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      coin_q      <= 3'd0;
      eject_q     <= 5'b00000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_q      <= coin_d;
      eject_q     <= eject_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      remaining_q <= remaining_d;
    end
  end

  assign eject     = eject_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Scoreboard bench for change_dispenser_ctrl: expected coin sequences are queued
// at start and compared against pulses captured from eject.
module tb_change_dispenser_ctrl;
  localparam int AMT_W = 10;
  localparam int P     = 4;
  localparam int G     = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             abort;
  logic [4:0]       hopper_empty;
  logic [4:0]       eject;
  logic             busy, done, err;
  logic [AMT_W-1:0] remaining;

  change_dispenser_ctrl #(.AMT_W(AMT_W), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount(amount), .abort(abort),
    .hopper_empty(hopper_empty), .eject(eject), .busy(busy), .done(done),
    .err(err), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_coin_q[$];
  logic [4:0] obs_coin_q[$];
  int         obs_len_q[$];
  int         onehot_viol = 0;

  // Pulse monitor: records each eject pulse (value, length in cycles).
  initial begin
    logic [4:0] prev;
    int         len;
    prev = 5'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev = 5'b0;
        len  = 0;
      end else begin
        if (prev != 5'b0 && eject !== prev) begin
          obs_coin_q.push_back(prev);
          obs_len_q.push_back(len);
        end
        if (eject != 5'b0 && eject != prev) len = 1;
        else if (eject != 5'b0) len++;
        if ($countones(eject) > 1) onehot_viol++;
        prev = eject;
      end
    end
  end

  function automatic int denom_of(input int idx);
    case (idx)
      4: return 100;
      3: return 50;
      2: return 25;
      1: return 10;
      default: return 5;
    endcase
  endfunction

  // Greedy reference: queues expected coins, returns leftover cents.
  task automatic push_expected(input int amt, input logic [4:0] empty_mask, output int rem);
    bit progress;
    rem = amt;
    progress = 1'b1;
    while (progress) begin
      progress = 1'b0;
      for (int i = 4; i >= 0; i--) begin
        if (!progress && !empty_mask[i] && denom_of(i) <= rem) begin
          exp_coin_q.push_back(5'(1 << i));
          rem -= denom_of(i);
          progress = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_done(input int limit, output int k, output bit timed_out);
    k = 0;
    timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (k >= limit) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic clear_queues();
    exp_coin_q.delete();
    obs_coin_q.delete();
    obs_len_q.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({eject, busy, done, err, remaining} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got eject=%b busy=%b done=%b err=%b rem=%0d, want all zero",
               eject, busy, done, err, remaining);
    end
  endtask

  task automatic test_greedy(input int amt, input logic [4:0] empty_mask, input string name);
    int rem_exp, n_exp, k;
    bit to;
    logic err_exp;
    logic [4:0] e, o;
    int len;
    clear_queues();
    push_expected(amt, empty_mask, rem_exp);
    n_exp   = exp_coin_q.size();
    err_exp = (rem_exp != 0);
    @(negedge clk);
    hopper_empty = empty_mask;
    amount = AMT_W'(amt);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    end
    wait_done(n_exp * (1 + P + G) + 10, k, to);
    n_checks++;
    if (to || k != n_exp * (1 + P + G) + 1) begin
      n_fail++;
      $display("FAIL %s done_latency: got %0d (timeout=%0b) want %0d", name, k, to,
               n_exp * (1 + P + G) + 1);
    end
    n_checks++;
    if (err !== err_exp || remaining !== AMT_W'(rem_exp)) begin
      n_fail++;
      $display("FAIL %s result: got err=%b rem=%0d want err=%b rem=%0d", name, err, remaining,
               err_exp, rem_exp);
    end
    #1;
    n_checks++;
    if (obs_coin_q.size() != n_exp) begin
      n_fail++;
      $display("FAIL %s coin_count: got %0d want %0d", name, obs_coin_q.size(), n_exp);
    end
    while (exp_coin_q.size() > 0 && obs_coin_q.size() > 0) begin
      e = exp_coin_q.pop_front();
      o = obs_coin_q.pop_front();
      len = obs_len_q.pop_front();
      n_checks++;
      if (o !== e || len != P) begin
        n_fail++;
        $display("FAIL %s coin: got eject=%b len=%0d want eject=%b len=%0d", name, o, len, e, P);
      end else
        $display("%s: coin eject=%b len=%0d ok", name, o, len);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== err_exp || remaining !== AMT_W'(rem_exp)) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b err=%b rem=%0d want 0 0 %b %0d", name,
               done, busy, err, remaining, err_exp, rem_exp);
    end
    $display("%s: amount=%0d done after %0d edges err=%b rem=%0d", name, amt, k, err, remaining);
    hopper_empty = 5'b0;
  endtask

  task automatic test_abort();
    clear_queues();
    @(negedge clk);
    amount = AMT_W'(100);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (eject !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort pre_eject: got %b want 10000", eject);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (eject !== 5'b0 || done !== 1'b1 || err !== 1'b1 || remaining !== AMT_W'(100)) begin
      n_fail++;
      $display("FAIL abort result: got eject=%b done=%b err=%b rem=%0d want 00000 1 1 100",
               eject, done, err, remaining);
    end
    #1;
    n_checks++;
    if (obs_len_q.size() != 1 || obs_len_q[0] != 2) begin
      n_fail++;
      $display("FAIL abort pulse_len: got %0d pulses want one of length 2", obs_len_q.size());
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b1 || remaining !== AMT_W'(100)) begin
      n_fail++;
      $display("FAIL abort idle_hold: got done=%b busy=%b err=%b rem=%0d want 0 0 1 100",
               done, busy, err, remaining);
    end
    $display("abort: amount=100 aborted in 2nd pulse cycle err=%b rem=%0d", err, remaining);
  endtask

  task automatic test_start_while_busy();
    int k, rem_exp;
    bit to;
    clear_queues();
    push_expected(40, 5'b0, rem_exp);
    @(negedge clk);
    amount = AMT_W'(40);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    k = 0;
    to = 1'b0;
    while (done !== 1'b1) begin
      if (k >= 60) begin
        to = 1'b1;
        break;
      end
      if (k == 3) begin
        amount = AMT_W'(10);
        start  = 1'b1;
        hopper_empty = 5'b00100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    n_checks++;
    if (to || k != 22 || err !== 1'b0 || remaining !== AMT_W'(0)) begin
      n_fail++;
      $display("FAIL busy_start: got k=%0d err=%b rem=%0d want k=22 err=0 rem=0", k, err,
               remaining);
    end
    #1;
    n_checks++;
    if (obs_coin_q.size() != 3 || obs_coin_q[0] !== 5'b00100 || obs_coin_q[1] !== 5'b00010
        || obs_coin_q[2] !== 5'b00001) begin
      n_fail++;
      $display("FAIL busy_start coins: got %0d coins want 25c,10c,5c", obs_coin_q.size());
    end
    $display("start_while_busy: done after %0d edges rem=%0d", k, remaining);
    hopper_empty = 5'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    @(negedge clk);
    amount = AMT_W'(100);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({eject, busy, done, err, remaining} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got eject=%b busy=%b done=%b err=%b rem=%0d want zeros",
               eject, busy, done, err, remaining);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || eject !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got busy=%b eject=%b want 0 00000", busy, eject);
    end
    $display("reset_mid_pulse: outputs cleared, busy=%b", busy);
    clear_queues();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    amount = '0;
    hopper_empty = 5'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_greedy(40, 5'b00000, "full_40");
    test_greedy(0, 5'b00000, "zero");
    test_greedy(185, 5'b00100, "no25_185");
    test_greedy(30, 5'b00001, "no5_30");
    test_greedy(7, 5'b00000, "odd_7");
    test_greedy(95, 5'b11111, "all_empty");
    test_abort();
    test_start_while_busy();
    test_reset_mid_pulse();
    n_checks++;
    if (onehot_viol != 0) begin
      n_fail++;
      $display("FAIL eject_onehot: got %0d multi-hot cycles want 0", onehot_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
